// File: rtl/sum_fifo_rx_pkg.sv
// Shared definitions for the row-sum receive FIFO: word width, default geometry
// and the pointer-width helper.
package sum_fifo_rx_pkg;

    localparam int BW_PSUM_DEF = 20;
    localparam int FRAME_DEF   = 16;
    localparam int DEPTH_DEF   = 32;

    // Stored sums carry four guard bits above the partial-sum width.
    function automatic int sum_w(input int bw_psum);
        return bw_psum + 4;
    endfunction

    function automatic int ptr_w(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/sum_fifo_rx_if.sv
// Handshake bundle between the partner sum output, the receive FIFO and the
// local core's sum input.
interface sum_fifo_rx_if #(
    parameter int W = 24
) ();
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         fifo_in_ready;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, fifo_in_ready
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, fifo_in_ready
    );
endinterface

// File: rtl/sum_fifo_mem.sv
// DEPTH x W register array with one write port and one registered read port.
// Only the read output register is reset; the array itself holds data only.
module sum_fifo_mem #(
    parameter int W     = 24,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // ---- read stage p1: popped word held until the next accepted pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sum_fifo_rx.sv
// Receive buffer for the inter-core row-sum exchange; ready once a full frame
// is held. Sticky overflow/underflow flags are built only with SUM_FIFO_RX_ERR_EN.
module sum_fifo_rx
    import sum_fifo_rx_pkg::*;
#(
    parameter  int bw_psum = BW_PSUM_DEF,
    parameter  int FRAME   = FRAME_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int W       = sum_w(bw_psum),
    localparam int AW      = ptr_w(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1,
    localparam int WW      = ptr_w(FRAME),
    localparam int FW      = $clog2(DEPTH / FRAME + 1)
) (
    input  logic           clk,
    input  logic           reset,
    sum_fifo_rx_if.slave   bus,
    output logic [CW-1:0]  count,
    output logic           full,
    output logic           empty,
    output logic           overflow,
    output logic           underflow
);

    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wr_word, rd_word;
    logic [FW-1:0] frames, frames_next;
    logic          ready_q;
    logic          push_ok, pop_ok, frame_in, frame_out;
    logic [W-1:0]  rd_data_p1;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // A push into a full buffer still lands when a pop frees the slot this cycle.
    always_comb begin
        pop_ok      = bus.rd_en && !empty;
        push_ok     = bus.wr_en && (!full || pop_ok);
        frame_in    = push_ok && (wr_word == WW'(FRAME - 1));
        frame_out   = pop_ok  && (rd_word == WW'(FRAME - 1));
        frames_next = frames;
        if (frame_in && !frame_out)      frames_next = frames + 1'b1;
        else if (!frame_in && frame_out) frames_next = frames - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            wr_word <= '0;
            rd_word <= '0;
            frames  <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wp      <= wp + 1'b1;
                wr_word <= frame_in ? '0 : wr_word + 1'b1;
            end
            if (pop_ok) begin
                rp      <= rp + 1'b1;
                rd_word <= frame_out ? '0 : rd_word + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            frames  <= frames_next;
            // Registered from the next-state count so ready shows right after the edge.
            ready_q <= (frames_next != '0);
        end
    end

    sum_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok),
        .waddr (wp),
        .wdata (bus.wr_data),
        .re    (pop_ok),
        .raddr (rp),
        .rdata (rd_data_p1)
    );

    assign bus.rd_data       = rd_data_p1;
    assign bus.fifo_in_ready = ready_q;

`ifdef SUM_FIFO_RX_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && !push_ok) overflow_q  <= 1'b1;
            if (bus.rd_en && empty)    underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sum_fifo_rx.sv
// Directed and randomized bench for sum_fifo_rx against a queue-based model.
module tb_sum_fifo_rx;
    import sum_fifo_rx_pkg::*;

    localparam int W     = sum_w(BW_PSUM_DEF);
    localparam int FRAME = FRAME_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SUM_FIFO_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] count;
    logic          full, empty, overflow, underflow;

    sum_fifo_rx_if #(.W(W)) bus ();

    sum_fifo_rx #(
        .bw_psum (BW_PSUM_DEF),
        .FRAME   (FRAME),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] q [$];
    logic [W-1:0] rd_exp;
    int           pushed, popped;
    bit           ovf, udf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rd_exp = '0;
        pushed = 0;
        popped = 0;
        ovf    = 1'b0;
        udf    = 1'b0;
    endtask

    function automatic bit ready_exp();
        return ((pushed / FRAME) - (popped / FRAME)) != 0;
    endfunction

    task automatic check_all(input string where);
        chk({where, ":rd_data"},   64'(bus.rd_data),       64'(rd_exp));
        chk({where, ":ready"},     64'(bus.fifo_in_ready), 64'(ready_exp()));
        chk({where, ":count"},     64'(count),             64'(q.size()));
        chk({where, ":empty"},     64'(empty),             64'(q.size() == 0));
        chk({where, ":full"},      64'(full),              64'(q.size() == DEPTH));
        chk({where, ":overflow"},  64'(overflow),          64'(ERR_EN & ovf));
        chk({where, ":underflow"}, 64'(underflow),         64'(ERR_EN & udf));
    endtask

    // One clock: drive strobes on negedge, advance model at posedge, sample 1 time unit later.
    task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input string where);
        bit pop_ok, push_ok;
        @(negedge clk);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        @(posedge clk);
        pop_ok  = r && (q.size() > 0);
        push_ok = w && ((q.size() < DEPTH) || pop_ok);
        if (pop_ok) begin
            rd_exp = q.pop_front();
            popped++;
        end else if (r) udf = 1'b1;
        if (push_ok) begin
            q.push_back(d);
            pushed++;
        end else if (w) ovf = 1'b1;
        #1;
        check_all(where);
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 1; i <= 16; i++) cyc(1'b1, W'(i), 1'b0, "push16");
        chk("push16_ready_end", 64'(bus.fifo_in_ready), 64'd1);
        chk("push16_count_end", 64'(count), 64'd16);

        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, '0, 1'b1, "pop16");
            chk("pop16_order", 64'(bus.rd_data), 64'(i));
        end
        chk("pop16_ready_end", 64'(bus.fifo_in_ready), 64'd0);
        chk("pop16_empty_end", 64'(empty), 64'd1);

        for (int i = 0; i < 15; i++) cyc(1'b1, W'($urandom), 1'b0, "push15");
        chk("push15_ready", 64'(bus.fifo_in_ready), 64'd0);
        chk("push15_count", 64'(count), 64'd15);
        cyc(1'b1, W'($urandom), 1'b0, "push15_fill");
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1, "push15_drain");

        for (int i = 0; i < 16; i++) cyc(1'b1, W'($urandom), 1'b0, "frameA");
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, W'($urandom), 1'b1, "frameA_drainB_fill");
            chk("frameAB_ready_held", 64'(bus.fifo_in_ready), 64'd1);
        end
        chk("frameB_count", 64'(count), 64'd16);
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1, "frameB_drain");
        chk("frameB_empty", 64'(empty), 64'd1);

        for (int i = 0; i < 33; i++) cyc(1'b1, W'($urandom), 1'b0, "push33");
        chk("push33_count", 64'(count), 64'd32);
        chk("push33_full", 64'(full), 64'd1);
        chk("push33_overflow", 64'(overflow), 64'(ERR_EN));
        for (int i = 0; i < 32; i++) cyc(1'b0, '0, 1'b1, "push33_drain");

        rd_exp = bus.rd_data === rd_exp ? rd_exp : rd_exp;
        cyc(1'b0, '0, 1'b1, "pop_empty");
        chk("pop_empty_underflow", 64'(underflow), 64'(ERR_EN));

        for (int i = 0; i < 16; i++) cyc(1'b1, W'($urandom), 1'b0, "pre_reset_fill");
        for (int i = 0; i < 5; i++)  cyc(1'b0, '0, 1'b1, "pre_reset_drain");
        bus.rd_en = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0, '0, 1'b0, "post_reset_idle");

        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 99) < 55), W'($urandom), ($urandom_range(0, 99) < 50), "random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
